// File: rtl/drag_race_pkg.sv
// Shared types and default constants for the drag race timer.
package drag_race_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        REACT = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4,
        FOUL  = 3'd5
    } state_t;

    localparam int unsigned CLK_HZ    = 50_000_000;
    localparam int unsigned TICK_DIV  = CLK_HZ / 1000;
    localparam int unsigned RT_DIGITS = 4;
    localparam int unsigned ET_DIGITS = 5;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; saturates at all-9s.
module bcd_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   value
);

    logic [4*DIGITS-1:0] next;
    logic                carry;
    logic                at_max;

    // Carry ripples through every digit within one cycle.
    always_comb begin
        next   = value;
        carry  = 1'b1;
        at_max = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (value[4*i +: 4] != 4'd9) at_max = 1'b0;
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    next[4*i +: 4] = 4'd0;
                end else begin
                    next[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry          = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset)                value <= '0;
        else if (clr)              value <= '0;
        else if (inc && !at_max)   value <= next;
    end

endmodule

// File: rtl/drag_race_timer.sv
// Reaction and elapsed time measurement for one lane, driven by the tree lights and beams.
module drag_race_timer #(
    parameter int unsigned TICK_DIV  = drag_race_pkg::TICK_DIV,
    parameter int unsigned RT_DIGITS = drag_race_pkg::RT_DIGITS,
    parameter int unsigned ET_DIGITS = drag_race_pkg::ET_DIGITS
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   G,
    input  logic                   R,
    input  logic                   SB,
    input  logic                   FB,
    output logic [4*RT_DIGITS-1:0] RT,
    output logic [4*ET_DIGITS-1:0] ET,
    output logic                   Running,
    output logic                   Done,
    output logic                   Foul
);
    import drag_race_pkg::*;

    localparam int unsigned     PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   LAST = PW'(TICK_DIV - 1);

    state_t          state;
    logic            sb_meta, sb_s, fb_meta, fb_s;
    logic [PW-1:0]   presc;
    logic            timing, tick, go, react_exit, rt_inc, et_inc;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sb_meta <= 1'b0;
            sb_s    <= 1'b0;
            fb_meta <= 1'b0;
            fb_s    <= 1'b0;
        end else begin
            sb_meta <= SB;
            sb_s    <= sb_meta;
            fb_meta <= FB;
            fb_s    <= fb_meta;
        end
    end

    assign timing     = (state == REACT) || (state == RUN);
    assign tick       = timing && (presc == LAST);
    assign go         = (state == ARMED) && !R && G;
    assign react_exit = (state == REACT) && !R && !sb_s;
    assign rt_inc     = (state == REACT) && tick;
    assign et_inc     = (state == RUN) && tick;

    always_ff @(posedge Clock) begin
        if (!Reset)                  presc <= '0;
        else if (go || react_exit)   presc <= '0;
        else if (timing)             presc <= tick ? '0 : presc + PW'(1);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state   <= IDLE;
            Running <= 1'b0;
            Done    <= 1'b0;
            Foul    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (sb_s) state <= ARMED;
                ARMED: begin
                    if (R) begin
                        state <= FOUL;
                        Foul  <= 1'b1;
                    end else if (G) begin
                        state   <= REACT;
                        Running <= 1'b1;
                    end else if (!sb_s) begin
                        state <= IDLE;
                    end
                end
                REACT: begin
                    if (R) begin
                        state   <= FOUL;
                        Foul    <= 1'b1;
                        Running <= 1'b0;
                    end else if (!sb_s) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fb_s) begin
                        state   <= DONE;
                        Done    <= 1'b1;
                        Running <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    bcd_counter #(.DIGITS(RT_DIGITS)) u_rt (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (go),
        .inc   (rt_inc),
        .value (RT)
    );

    bcd_counter #(.DIGITS(ET_DIGITS)) u_et (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (react_exit),
        .inc   (et_inc),
        .value (ET)
    );

endmodule

// File: tb/tb_drag_race_timer.sv
// Scoreboard bench: lane A (TICK_DIV=10) and lane B (TICK_DIV=2) run concurrently on one clock.
module tb_drag_race_timer;

    typedef struct {
        string       name;
        logic [15:0] rt;
        logic [19:0] et;
        logic        running;
        logic        done;
        logic        foul;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst_a = 1'b0, g_a = 1'b0, r_a = 1'b0, sb_a = 1'b0, fb_a = 1'b0;
    logic        rst_b = 1'b0, g_b = 1'b0, r_b = 1'b0, sb_b = 1'b0, fb_b = 1'b0;
    logic [15:0] rt_a, rt_b;
    logic [19:0] et_a, et_b;
    logic        run_a, done_a, foul_a, run_b, done_b, foul_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   probe_cnt_a = 0, probe_cnt_b = 0;
    int   seen_a = 0, seen_b = 0;
    logic pd_a = 1'b0, pf_a = 1'b0, pd_b = 1'b0, pf_b = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clock = ~clock;

    drag_race_timer #(.TICK_DIV(10), .RT_DIGITS(4), .ET_DIGITS(5)) dut_a (
        .Clock(clock), .Reset(rst_a), .G(g_a), .R(r_a), .SB(sb_a), .FB(fb_a),
        .RT(rt_a), .ET(et_a), .Running(run_a), .Done(done_a), .Foul(foul_a)
    );

    drag_race_timer #(.TICK_DIV(2), .RT_DIGITS(4), .ET_DIGITS(5)) dut_b (
        .Clock(clock), .Reset(rst_b), .G(g_b), .R(r_b), .SB(sb_b), .FB(fb_b),
        .RT(rt_b), .ET(et_b), .Running(run_b), .Done(done_b), .Foul(foul_b)
    );

    function automatic exp_t mk(string n, logic [15:0] rt, logic [19:0] et,
                                logic run, logic dn, logic fl);
        exp_t e;
        e.name = n; e.rt = rt; e.et = et; e.running = run; e.done = dn; e.foul = fl;
        return e;
    endfunction

    function automatic void compare(string lane, exp_t e, logic [15:0] rt, logic [19:0] et,
                                    logic run, logic dn, logic fl);
        total++;
        if (rt !== e.rt || et !== e.et || run !== e.running || dn !== e.done || fl !== e.foul) begin
            bad++;
            $display("FAIL %s/%s: got RT=%h ET=%h run=%b done=%b foul=%b, want RT=%h ET=%h run=%b done=%b foul=%b",
                     lane, e.name, rt, et, run, dn, fl, e.rt, e.et, e.running, e.done, e.foul);
        end
    endfunction

    // Lane monitors: check on explicit probes and whenever Done or Foul rises.
    always @(negedge clock) begin
        if (probe_cnt_a != seen_a || (done_a === 1'b1 && pd_a !== 1'b1) || (foul_a === 1'b1 && pf_a !== 1'b1)) begin
            seen_a = probe_cnt_a;
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL A/unexpected: got done=%b foul=%b, want no event", done_a, foul_a);
            end else begin
                compare("A", q_a.pop_front(), rt_a, et_a, run_a, done_a, foul_a);
            end
        end
        pd_a = done_a;
        pf_a = foul_a;
    end

    always @(negedge clock) begin
        if (probe_cnt_b != seen_b || (done_b === 1'b1 && pd_b !== 1'b1) || (foul_b === 1'b1 && pf_b !== 1'b1)) begin
            seen_b = probe_cnt_b;
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL B/unexpected: got done=%b foul=%b, want no event", done_b, foul_b);
            end else begin
                compare("B", q_b.pop_front(), rt_b, et_b, run_b, done_b, foul_b);
            end
        end
        pd_b = done_b;
        pf_b = foul_b;
    end

    task automatic cycles(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic probe_a(string n, logic [15:0] rt, logic [19:0] et, logic run, logic dn, logic fl);
        q_a.push_back(mk(n, rt, et, run, dn, fl));
        probe_cnt_a++;
    endtask

    task automatic probe_b(string n, logic [15:0] rt, logic [19:0] et, logic run, logic dn, logic fl);
        q_b.push_back(mk(n, rt, et, run, dn, fl));
        probe_cnt_b++;
    endtask

    task automatic reset_a();
        rst_a = 1'b0; g_a = 1'b0; r_a = 1'b0; sb_a = 1'b0; fb_a = 1'b0;
        cycles(1);
        rst_a = 1'b1;
    endtask

    task automatic lane_a();
        rst_a = 1'b0;
        cycles(3);
        rst_a = 1'b1;
        probe_a("reset", 16'h0, 20'h0, 0, 0, 0);

        // Normal run: REACT entered at edge k, SB_s low sampled at k+12343.
        sb_a = 1'b1;
        cycles(4);
        g_a = 1'b1;
        cycles(1);
        cycles(100);
        probe_a("react_100", 16'h0010, 20'h0, 1, 0, 0);
        cycles(12240);
        sb_a = 1'b0;
        q_a.push_back(mk("normal", 16'h1234, 20'h05678, 0, 1, 0));
        cycles(56780);
        fb_a = 1'b1;
        cycles(10);
        r_a = 1'b1;
        cycles(2);
        r_a = 1'b0; fb_a = 1'b0;
        probe_a("done_hold", 16'h1234, 20'h05678, 0, 1, 0);

        reset_a();
        probe_a("reset_after_done", 16'h0, 20'h0, 0, 0, 0);

        // Red-light foul from ARMED.
        sb_a = 1'b1;
        cycles(4);
        q_a.push_back(mk("red_foul", 16'h0, 20'h0, 0, 0, 1));
        r_a = 1'b1;
        cycles(1);
        r_a = 1'b0;
        cycles(10);
        sb_a = 1'b0;
        g_a = 1'b1;
        cycles(3);
        g_a = 1'b0;
        probe_a("foul_hold", 16'h0, 20'h0, 0, 0, 1);

        // Simultaneous G and R in ARMED.
        reset_a();
        sb_a = 1'b1;
        cycles(4);
        q_a.push_back(mk("g_and_r", 16'h0, 20'h0, 0, 0, 1));
        g_a = 1'b1; r_a = 1'b1;
        cycles(1);
        g_a = 1'b0; r_a = 1'b0;
        cycles(3);

        // Unstage before green; an R pulse afterwards must not foul from IDLE.
        reset_a();
        sb_a = 1'b1;
        cycles(4);
        sb_a = 1'b0;
        cycles(4);
        probe_a("unstage", 16'h0, 20'h0, 0, 0, 0);
        r_a = 1'b1;
        cycles(1);
        r_a = 1'b0;
        cycles(1);
        probe_a("unstage_idle", 16'h0, 20'h0, 0, 0, 0);

        // Re-stage, run to ET = 42, then reset mid-RUN.
        sb_a = 1'b1;
        cycles(4);
        g_a = 1'b1;
        cycles(1);
        g_a = 1'b0;
        cycles(25);
        probe_a("restage_react", 16'h0002, 20'h0, 1, 0, 0);
        sb_a = 1'b0;
        cycles(3);
        cycles(425);
        probe_a("run_42", 16'h0002, 20'h00042, 1, 0, 0);
        rst_a = 1'b0;
        cycles(1);
        rst_a = 1'b1;
        probe_a("reset_mid_run", 16'h0, 20'h0, 0, 0, 0);
        g_a = 1'b1;
        cycles(5);
        probe_a("no_rearm", 16'h0, 20'h0, 0, 0, 0);
        sb_a = 1'b1;
        cycles(4);
        probe_a("rearm", 16'h0, 20'h0, 1, 0, 0);
        cycles(2);
    endtask

    task automatic lane_b();
        rst_b = 1'b0;
        cycles(3);
        rst_b = 1'b1;
        probe_b("reset", 16'h0, 20'h0, 0, 0, 0);

        // Saturation: ticks every 2 cycles from edge k, SB held for 25000 cycles.
        sb_b = 1'b1;
        cycles(4);
        g_b = 1'b1;
        cycles(1);
        cycles(19996);
        probe_b("rt_9998", 16'h9998, 20'h0, 1, 0, 0);
        cycles(2);
        probe_b("rt_9999", 16'h9999, 20'h0, 1, 0, 0);
        cycles(5002);
        probe_b("rt_sat", 16'h9999, 20'h0, 1, 0, 0);
        sb_b = 1'b0;
        cycles(3);
        cycles(100);
        probe_b("et_50", 16'h9999, 20'h00050, 1, 0, 0);
        fb_b = 1'b1;
        q_b.push_back(mk("sat_done", 16'h9999, 20'h00051, 0, 1, 0));
        cycles(10);
    endtask

    initial begin
        fork
            lane_a();
            lane_b();
        join
        cycles(5);
        while (q_a.size() != 0) begin
            exp_t e;
            e = q_a.pop_front();
            total++; bad++;
            $display("FAIL A/%s: got no event, want done=%b foul=%b", e.name, e.done, e.foul);
        end
        while (q_b.size() != 0) begin
            exp_t e;
            e = q_b.pop_front();
            total++; bad++;
            $display("FAIL B/%s: got no event, want done=%b foul=%b", e.name, e.done, e.foul);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drag_race_timer.md
# drag_race_timer

Downstream stage of the christmas-tree light controller. Consumes the tree's Green (G) and Red (R) lights plus the stage and finish beams, and measures driver reaction time (green to stage-beam exit) and elapsed time (stage-beam exit to finish beam). Both times are in milliseconds, as BCD for the seven-segment display stage. A red-light start is flagged as a foul.

## Interface
- TICK_DIV, 50_000: Clock cycles per 1 ms tick (50 MHz board clock); benches override it with small values.
- RT_DIGITS, 4: BCD digits of reaction time (max 9.999 s).
- ET_DIGITS, 5: BCD digits of elapsed time (max 99.999 s).
- Clock  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- G  in  1  tree green light, synchronous to Clock.
- R  in  1  tree red light, synchronous to Clock.
- SB  in  1  stage beam, raw and asynchronous; 1 = car in beam.
- FB  in  1  finish beam, raw and asynchronous; 1 = car breaking the beam.
- RT  out  4*RT_DIGITS  reaction time, BCD ms.
- ET  out  4*ET_DIGITS  elapsed time, BCD ms.
- Running  out  1  high in REACT and RUN.
- Done  out  1  run completed; results valid.
- Foul  out  1  red-light foul.

## Operation
- SB and FB each pass through a 2-flop synchronizer, giving SB_s and FB_s. G and R are used directly.
- States are IDLE, ARMED, REACT, RUN, DONE, FOUL.
- **IDLE:** go to ARMED when SB_s = 1.
- **ARMED:** conditions are checked in this order:
  - R = 1: go to FOUL.
  - G = 1: go to REACT; clear RT and the prescaler.
  - SB_s = 0: go to IDLE.
  - R has priority over G and over SB_s = 0 in the same cycle.
- **REACT:**
  - Each ms tick increments RT.
  - R = 1: go to FOUL.
  - SB_s = 0: go to RUN. RT freezes; clear ET and the prescaler.
- **RUN:**
  - Each ms tick increments ET.
  - FB_s = 1: go to DONE; ET freezes.
  - SB_s is ignored.
- **DONE and FOUL** are terminal; only Reset leaves them. G, R, SB and FB are ignored there.
- **Prescaler:** counts 0..TICK_DIV-1 and emits a one-cycle tick at TICK_DIV-1, then wraps to 0. It runs only in REACT and RUN.
- **Count rules:**
  - Times are truncated, not rounded: RT = completed ticks since entry to REACT.
  - RT and ET saturate at all-9s (0x9999 / 0x99999) and hold there. There is no wrap and no timeout; the state machine keeps waiting for its exit event.
- **Outputs:** Done is high only in DONE, Foul only in FOUL. In FOUL, RT and ET keep their value at the moment of the foul (0 when the foul is from ARMED).
- **Reset:** when Reset = 0 at a clock edge, the block goes to IDLE and every output, counter and synchronizer flop becomes 0: RT = 0, ET = 0, Running = 0, Done = 0, Foul = 0. This holds in any state, including mid-REACT and mid-RUN.

## Timing
- SB_s and FB_s lag the raw beams by 2 cycles.
- The tree drives R high one cycle after the beam drops during an amber. The state machine therefore samples R = 1 no later than the cycle it samples SB_s = 0. Combined with R priority, an early exit is always recorded as FOUL, never IDLE.
- All outputs are registered. State and outputs update on the same edge as the transition, so Done and Foul rise on the edge that enters DONE or FOUL.
- A BCD increment completes in one cycle: a carry ripples through all digits combinationally within that cycle.
- A tick coinciding with an exit event: the increment is applied on that edge, then the value freezes.

## Structure
- **drag_race_pkg** holds:
  - the state enum, 3 bits, in the order IDLE..FOUL = 0..5;
  - the default constants CLK_HZ = 50_000_000 and TICK_DIV = CLK_HZ/1000;
  - RT_DIGITS and ET_DIGITS.
- **bcd_counter** is a sub-module instantiated twice (RT and ET).
  - Parameter: DIGITS.
  - Inputs: Clock, Reset, clr, inc.
  - Output: value.
  - clr has priority over inc, and the counter saturates at all-9s.
- The prescaler, synchronizers and state machine live in drag_race_timer.

## Test plan
- **Normal run**, TICK_DIV = 10: raise SB, then G; drop SB after 12,340 cycles; raise FB after a further 56,780 cycles. Expect RT = 0x1234, ET = 0x05678, Done = 1, Foul = 0, Running = 0.
- **Red-light foul:** SB = 1, enter ARMED, pulse R = 1 with G = 0. Expect Foul = 1 on the next edge, RT = 0, ET = 0, Done = 0, and Foul held until Reset.
- **Simultaneous G and R** in ARMED on the same cycle: expect FOUL (Foul = 1, Running = 0).
- **Unstage before green:** SB = 1 then SB = 0 with G = R = 0. Expect return to IDLE with all outputs 0; re-staging re-arms normally.
- **Saturation**, TICK_DIV = 2: G high, SB held for 25,000 cycles. Expect RT = 0x9999, held, with Running = 1; then drop SB and raise FB, and ET counts normally from 0.
- **Reset mid-RUN:** Reset = 0 for one cycle while ET = 0x00042. Expect RT = ET = 0, Running = Done = Foul = 0 after that edge, and the state machine in IDLE (re-arming requires SB_s = 1).
